// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS fetch unit: FSM state encoding and
// the jump / branch target arithmetic used by the next-PC mux.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [31:0] instr);
        return {pcplus4[31:28], instr[25:0], 2'b00};
    endfunction

    // Word offset shifted to bytes; the top two immediate bits fall off.
    function automatic logic [31:0] branch_target(input logic [31:0] pcplus4,
                                                  input logic [31:0] signimm);
        return pcplus4 + {signimm[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jump beats beq, which beats bne, which
// beats the sequential pc+4 path. All arithmetic wraps modulo 2^32.
module mips_next_pc
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] signimm_i,
    input  logic        jump_i,
    input  logic        pcsrc_i,
    input  logic        pcsrc1_i,
    output logic [31:0] pcplus4_o,
    output logic [31:0] next_pc_o
);

    assign pcplus4_o = pc_i + WORD_BYTES;

    always_comb begin
        next_pc_o = pcplus4_o;
        if (jump_i) begin
            next_pc_o = jump_target(pcplus4_o, instr_i);
        end else if (pcsrc_i || pcsrc1_i) begin
            next_pc_o = branch_target(pcplus4_o, signimm_i);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch / next-PC stage: boot, fetch over a req/ready handshake,
// then hold the word for execute. Define FETCH_PERF_CNT_EN to get a
// retired-instruction counter on retired_cnt (tied to 0 otherwise).
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic        pcsrc1,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_err,
    output logic [31:0] retired_cnt
);

    localparam logic [31:0] TMO_LIMIT = IMEM_TIMEOUT[31:0];

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         valid_q;
    logic         req_q;
    logic         err_q;
    logic [31:0]  tmo_q;
    logic [31:0]  next_pc_d;

    mips_next_pc u_next_pc (
        .pc_i      (pc_q),
        .instr_i   (instr_q),
        .signimm_i (signimm),
        .jump_i    (jump),
        .pcsrc_i   (pcsrc),
        .pcsrc1_i  (pcsrc1),
        .pcplus4_o (pcplus4),
        .next_pc_o (next_pc_d)
    );

    // The timeout counter saturates at the limit so the sticky flag is set once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                S_BOOT: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= S_EXEC;
                    end else if (TMO_LIMIT != 32'd0 && tmo_q != TMO_LIMIT) begin
                        tmo_q <= tmo_q + 32'd1;
                        if (tmo_q + 32'd1 == TMO_LIMIT) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (!stall) begin
                        pc_q    <= next_pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_BOOT;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

`ifdef FETCH_PERF_CNT_EN
    logic        retire;
    logic [31:0] retired_q;

    assign retire = (state_q == S_EXEC) && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch and next-PC stage that sits directly upstream of the single-cycle controller/datapath.
- Holds the architectural PC and fetches one instruction word from instruction memory over a request/ready handshake.
- Presents the word (op, funct, immediate fields) to decode, then commits the next PC selected by the controller's branch, branch-not-equal and jump outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; low two bits must be 00.
IMEM_TIMEOUT, 0, cycles allowed in S_FETCH before fetch_err is raised; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  instruction memory read request
imem_addr  output  32  word-aligned fetch address (always equals pc)
imem_ready  input  1  imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  registered instruction presented to decode
instr_valid  output  1  instr holds a live instruction being executed
stall  input  1  datapath not ready to retire; hold PC and instr
pcsrc  input  1  beq taken (branch & zero)
pcsrc1  input  1  bne taken (branchne & ~zero)
jump  input  1  j-type jump
signimm  input  32  sign/zero-extended immediate from the datapath
pc  output  32  current PC
pcplus4  output  32  pc + 4, combinational, used for jal/link
fetch_err  output  1  sticky timeout flag; cleared only by reset
retired_cnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, retired_cnt=0, state=S_BOOT.
  - Reset asserted mid-fetch drops imem_req immediately; any later imem_ready is ignored.
- FSM states S_BOOT, S_FETCH, S_EXEC, encoded in the shared package.
- S_BOOT: imem_req=0 for exactly one cycle after reset releases, then go to S_FETCH.
- S_FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready: instr<=imem_rdata, instr_valid<=1, go to S_EXEC. Fetch latency is 1 cycle plus memory wait cycles.
  - imem_ready seen outside S_FETCH is ignored.
- S_EXEC:
  - imem_req=0; the controller and datapath decode instr combinationally.
  - If stall=1: pc, instr and instr_valid are held.
  - If stall=0: pc<=next_pc, instr_valid<=0, retire event, go to S_FETCH.
- next_pc priority: jump > pcsrc > pcsrc1 > pcplus4.
  - Jump target: {pcplus4[31:28], instr[25:0], 2'b00}.
  - Branch target: pcplus4 + {signimm[29:0], 2'b00}.
  - pcsrc and pcsrc1 both asserted is illegal; pcsrc wins.
- Control inputs are sampled only in S_EXEC with stall=0; they are don't-care otherwise.
- All adds are 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0, and branch targets wrap the same way.
- Timeout (IMEM_TIMEOUT>0): a counter runs in S_FETCH and resets on leaving it. When it reaches IMEM_TIMEOUT, fetch_err<=1 (sticky) and the FSM keeps requesting.
- Throughput: best case one instruction per 2 cycles (fetch plus execute).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: retired_cnt increments by 1 on every retire event (S_EXEC with stall=0) and wraps at 2^32.
- Undefined: retired_cnt is tied to 0 and no counter flops are synthesized.
- The port list is identical in both builds.

Decomposition:
- Shared package mips_fetch_pkg holds:
  - fetch_state_t enum (S_BOOT, S_FETCH, S_EXEC).
  - Constant WORD_BYTES=4.
  - Function jump_target(pcplus4, instr) and function branch_target(pcplus4, signimm).
- One natural sub-module: mips_next_pc, the combinational priority mux and target adders. The FSM, PC register, timeout and counters stay in the top module.

Test Plan:
- Reset release, imem_ready every cycle -> imem_addr 0,4,8 on successive fetches; one retire per 2 cycles; instr_valid pulses.
- In S_EXEC with pc=0x100, pcsrc=1, signimm=0xFFFF_FFFE -> next fetch address 0x0FC; with pcsrc1=1, signimm=3 instead -> 0x110.
- pc=0x4000_0010, jump=1, instr[25:0]=0x0000040 -> next address 0x4000_0100; jump=1 together with pcsrc=1 -> jump wins.
- imem_ready delayed 3 cycles -> imem_req held 3 cycles, imem_addr stable; stall=1 for 2 cycles in S_EXEC -> pc/instr unchanged, no retire.
- IMEM_TIMEOUT=4, imem_ready never asserts -> fetch_err=1 after 4 cycles in S_FETCH and stays 1; reset low mid-fetch -> imem_req=0 with no clock edge, pc=RESET_PC.
- FETCH_PERF_CNT_EN defined, 10 retires with interleaved stalls -> retired_cnt=10; macro undefined -> retired_cnt stays 0.
